// File: rtl/nibble_serial_add_seq_pkg.sv
// Shared types and constants for the nibble-serial add sequencer.
package nibble_serial_add_seq_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/nibble_serial_add_seq.sv
// Feeds a WIDTH-bit add to an external pipelined 4-bit adder one nibble at a
// time (LSB first), chaining carries and collecting the sum for a consumer.
module nibble_serial_add_seq
  import nibble_serial_add_seq_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ADD_LAT = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WIDTH-1:0]    in_a,
  input  logic [WIDTH-1:0]    in_b,
  input  logic                in_cin,
  output logic [NIBBLE_W-1:0] add_a,
  output logic [NIBBLE_W-1:0] add_b,
  output logic                add_cin,
  input  logic [NIBBLE_W-1:0] add_sum,
  input  logic                add_cout,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_sum,
  output logic                out_cout
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int CNT_W = $clog2(ADD_LAT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ADD_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_cnt;
  logic [WIDTH-1:0]    r_op_a;
  logic [WIDTH-1:0]    r_op_b;
  logic                r_carry;
  logic                r_in_ready;
  logic                r_out_valid;
  logic [WIDTH-1:0]    r_out_sum;
  logic                r_out_cout;
  logic [NIBBLE_W-1:0] r_add_a;
  logic [NIBBLE_W-1:0] r_add_b;
  logic                r_add_cin;

  logic [IDX_W-1:0]    w_next_idx;
  logic [NIBBLE_W-1:0] w_next_a;
  logic [NIBBLE_W-1:0] w_next_b;

  // Next nibble of the captured operands; wraps harmlessly on the last nibble.
  assign w_next_idx = r_idx + IDX_W'(1);
  assign w_next_a   = r_op_a[w_next_idx*NIBBLE_W +: NIBBLE_W];
  assign w_next_b   = r_op_b[w_next_idx*NIBBLE_W +: NIBBLE_W];

  // Sequencer FSM; adder operands are registered so they stay stable from
  // ISSUE until the nibble result is sampled at the end of WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_carry     <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_cout  <= 1'b0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_add_cin   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_op_a     <= in_a;
            r_op_b     <= in_b;
            r_carry    <= in_cin;
            r_idx      <= '0;
            r_out_sum  <= '0;
            r_out_cout <= 1'b0;
            r_add_a    <= in_a[NIBBLE_W-1:0];
            r_add_b    <= in_b[NIBBLE_W-1:0];
            r_add_cin  <= in_cin;
            r_in_ready <= 1'b0;
            r_state    <= ST_ISSUE;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        ST_ISSUE: begin
          r_cnt   <= CNT_LOAD;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (r_cnt == CNT_ONE) begin
            r_out_sum[r_idx*NIBBLE_W +: NIBBLE_W] <= add_sum;
            r_carry <= add_cout;
            if (r_idx == LAST_IDX) begin
              r_out_valid <= 1'b1;
              r_out_cout  <= add_cout;
              r_add_a     <= '0;
              r_add_b     <= '0;
              r_add_cin   <= 1'b0;
              r_state     <= ST_DONE;
            end else begin
              r_idx     <= w_next_idx;
              r_add_a   <= w_next_a;
              r_add_b   <= w_next_b;
              r_add_cin <= add_cout;
              r_state   <= ST_ISSUE;
            end
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        ST_DONE: begin
          // in_ready only returns the cycle after the result handshake.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_out_valid <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_add_a     <= '0;
          r_add_b     <= '0;
          r_add_cin   <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_cout  = r_out_cout;
  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign add_cin   = r_add_cin;

endmodule

// File: tb/tb_nibble_serial_add_seq.sv
// Self-checking bench: sequencer plus a 2-stage 4-bit adder model, table
// vectors with a result scoreboard and hand-written multi-cycle sequences.
module tb_nibble_serial_add_seq;

  localparam int WIDTH   = 16;
  localparam int ADD_LAT = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [WIDTH-1:0]  in_a = '0;
  logic [WIDTH-1:0]  in_b = '0;
  logic              in_cin = 1'b0;
  logic [3:0]        add_a, add_b, add_sum;
  logic              add_cin, add_cout;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WIDTH-1:0]  out_sum;
  logic              out_cout;

  nibble_serial_add_seq #(.WIDTH(WIDTH), .ADD_LAT(ADD_LAT)) dut (
    .clk(clk), .reset(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout)
  );

  always #5 clk = ~clk;

  // Two-stage pipelined 4-bit adder: operands registered, then sum registered.
  logic [3:0] p_a, p_b;
  logic       p_c;
  logic [4:0] p_res;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_a <= '0; p_b <= '0; p_c <= 1'b0; p_res <= '0;
    end else begin
      p_a   <= add_a;
      p_b   <= add_b;
      p_c   <= add_cin;
      p_res <= {1'b0, p_a} + {1'b0, p_b} + {4'b0000, p_c};
    end
  end
  assign add_sum  = p_res[3:0];
  assign add_cout = p_res[4];

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
  } res_t;

  vec_t vecs[6];
  res_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   lat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one request at the current negedge; afterwards we sit in cycle 1.
  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    res_t r;
    @(negedge clk);
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = c;
    r.sum  = a + b + {{(WIDTH-1){1'b0}}, c};
    r.cout = ({1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c}) >> WIDTH;
    sb_q.push_back(r);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid, counting from cycle 1; optionally check add_cin on ISSUE cycles.
  task automatic wait_result(input bit chk_cin);
    lat = 1;
    while (!out_valid && lat < 100) begin
      if (chk_cin && ((lat - 1) % (ADD_LAT + 1) == 0))
        check("add_cin_on_issue", {31'd0, add_cin}, 32'd1);
      @(negedge clk);
      lat++;
    end
    check("out_valid_cycle", lat, 32'd13);
  endtask

  task automatic compare_pop();
    res_t r;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      r = sb_q.pop_front();
      check("out_sum", {16'd0, out_sum}, {16'd0, r.sum});
      check("out_cout", {31'd0, out_cout}, {31'd0, r.cout});
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
    check("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] held_sum;
    logic             held_cout;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[3] = '{16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};

    // Reset values
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_sum", {16'd0, out_sum}, 32'd0);
    check("rst_out_cout", {31'd0, out_cout}, 32'd0);
    check("rst_add_a", {28'd0, add_a}, 32'd0);
    check("rst_add_cin", {31'd0, add_cin}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors; the scoreboard model is cross-checked against the table.
    for (int i = 0; i < 6; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].cin);
      check("table_model_sum", {16'd0, sb_q[sb_q.size()-1].sum}, {16'd0, vecs[i].exp_sum});
      wait_result(i == 1);
      check("add_a_idle_done", {28'd0, add_a}, 32'd0);
      check("vec_sum", {16'd0, out_sum}, {16'd0, vecs[i].exp_sum});
      check("vec_cout", {31'd0, out_cout}, {31'd0, vecs[i].exp_cout});
      compare_pop();
      handshake();
    end

    // Backpressure: result held, in_valid ignored for 5 cycles.
    launch(16'h1357, 16'h2468, 1'b0);
    wait_result(1'b0);
    held_sum = out_sum; held_cout = out_cout;
    in_valid = 1'b1; in_a = 16'hDEAD; in_b = 16'hBEEF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_sum_stable", {16'd0, out_sum}, {16'd0, held_sum});
      check("bp_cout_stable", {31'd0, out_cout}, {31'd0, held_cout});
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    compare_pop();
    handshake();

    // Reset during WAIT of nibble 2 (cycle 8).
    launch(16'h1234, 16'h1111, 1'b0);
    for (int k = 1; k < 8; k++) @(negedge clk);
    check("mid_add_a_nib2", {28'd0, add_a}, 32'd2);
    check("mid_add_b_nib2", {28'd0, add_b}, 32'd1);
    void'(sb_q.pop_back());
    rst_n = 1'b0;
    #1;
    check("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_out_sum", {16'd0, out_sum}, 32'd0);
    check("mrst_out_cout", {31'd0, out_cout}, 32'd0);
    check("mrst_add_a", {28'd0, add_a}, 32'd0);
    check("mrst_add_b", {28'd0, add_b}, 32'd0);
    check("mrst_add_cin", {31'd0, add_cin}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    launch(16'h00FF, 16'h0001, 1'b0);
    wait_result(1'b0);
    check("post_rst_sum", {16'd0, out_sum}, 32'h0100);
    check("post_rst_cout", {31'd0, out_cout}, 32'd0);
    compare_pop();
    handshake();

    // Back-to-back with in_valid held and out_ready=1.
    out_ready = 1'b1;
    launch(16'h0001, 16'h0001, 1'b0);
    in_valid = 1'b1; in_a = 16'hFFFF; in_b = 16'h0001; in_cin = 1'b0;
    sb_q.push_back('{16'h0000, 1'b1});
    wait_result(1'b0);
    check("b2b_first_sum", {16'd0, out_sum}, 32'h0002);
    compare_pop();
    @(negedge clk);
    check("b2b_in_ready_after_hs", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    check("b2b_accepted", {31'd0, in_ready}, 32'd0);
    check("b2b_add_a", {28'd0, add_a}, 32'hF);
    in_valid = 1'b0;
    wait_result(1'b0);
    check("b2b_second_cout", {31'd0, out_cout}, 32'd1);
    compare_pop();
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b_idle", {31'd0, in_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nibble_serial_add_seq.md
# nibble_serial_add_seq

Operand sequencer and result collector that wraps the 2-cycle pipelined 4-bit carry-select adder. It accepts a WIDTH-bit add request over a valid/ready handshake and feeds the adder one nibble at a time, least significant first. It chains each nibble's carry-out into the next nibble's carry-in and assembles the WIDTH-bit sum plus final carry for a downstream consumer. The adder is instantiated beside this block, not inside it; this block drives the adder's operand and carry-in ports and reads its registered sum and carry-out.

## Interface
- WIDTH, 16: operand/sum width; multiple of 4, ≥ 4. NIB = WIDTH/4.
- ADD_LAT, 2: cycles from the adder's operands being driven to its registered result being valid; ≥ 1.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset. It clears all state immediately, independent of clk.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request; 1 only in IDLE.
- in_a, in_b  in  WIDTH  operands.
- in_cin  in  1  carry-in of the whole add.
- add_a, add_b  out  4  current nibble driven to the adder.
- add_cin  out  1  carry-in driven to the adder.
- add_sum  in  4  adder registered sum.
- add_cout  in  1  adder registered carry-out.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH  assembled sum.
- out_cout  out  1  carry-out of the most significant nibble.

## Operation
- States:
  - IDLE: in_ready=1.
  - ISSUE: drive nibble idx.
  - WAIT: count ADD_LAT cycles.
  - DONE: out_valid=1.
- IDLE → ISSUE on in_valid && in_ready. On that edge, in_a, in_b and in_cin are captured, idx is set to 0, and the carry register is set to in_cin.
- ISSUE lasts exactly 1 cycle, then → WAIT with the wait counter loaded to ADD_LAT.
- WAIT decrements the counter each cycle. On the cycle the counter reaches 1 (the ADD_LAT-th cycle after ISSUE):
  - out_sum[4*idx+:4] ← add_sum, and carry ← add_cout.
  - If idx == NIB-1: → DONE.
  - Else: idx increments and the state → ISSUE.
- While in ISSUE and WAIT:
  - add_a = op_a[4*idx+:4], add_b = op_b[4*idx+:4], add_cin = carry.
  - These values are held stable until the nibble's result is sampled.
- In IDLE and DONE, add_a, add_b and add_cin are 0.
- DONE:
  - out_sum and out_cout (= carry) are held stable while out_ready=0.
  - out_valid && out_ready → IDLE.
  - in_ready rises the following cycle; a new request is never accepted in the same cycle as a result handshake.
- in_valid is ignored outside IDLE; operands are sampled only on acceptance.
- out_sum bits are cleared on acceptance, so no stale data from a previous op is visible.
- Arithmetic: {out_cout, out_sum} = in_a + in_b + in_cin, exact modulo 2^(WIDTH+1).

## Timing
- Reset values: in_ready=1, out_valid=0, out_sum=0, out_cout=0, add_a=0, add_b=0, add_cin=0, state=IDLE.
- Count the acceptance cycle as cycle 0. Nibble k is in ISSUE at cycle 1+k*(ADD_LAT+1). out_valid is first 1 in cycle 1+NIB*(ADD_LAT+1); for the defaults this is cycle 13.
- Throughput: one add per 2+NIB*(ADD_LAT+1) cycles when out_ready is held at 1.
- Reset asserted mid-operation (any state):
  - Aborts the operation; all outputs take their reset values asynchronously.
  - The external adder shares the same reset, so no stale in-flight nibble survives.
  - After release, the block is in IDLE with in_ready=1.

## Structure
- Shared package: state enum typedef (IDLE, ISSUE, WAIT, DONE) and constant NIBBLE_W = 4.
- Single module with one FSM, a nibble index counter and a latency countdown. No sub-module; the 4-bit adder is connected externally.

## Test plan
- Bench configuration for every scenario: WIDTH=16, ADD_LAT=2, with the pipelined 4-bit adder attached.
- Basic add: A=0x1234, B=0x4321, cin=0 → out_sum=0x5555, out_cout=0, out_valid rises in cycle 13.
- Full carry ripple: A=0xFFFF, B=0x0000, cin=1 → out_sum=0x0000, out_cout=1; add_cin=1 on every ISSUE.
- Top overflow: A=0x8000, B=0x8000, cin=0 → out_sum=0x0000, out_cout=1.
- Backpressure: out_ready held 0 for 5 cycles after out_valid → out_sum/out_cout stable, in_ready=0, in_valid ignored; then handshake → in_ready=1 next cycle.
- Reset mid-op: reset=0 during WAIT of nibble 2 → all outputs reset values immediately. After release, A=0x00FF, B=0x0001 → 0x0100, out_cout=0.
- Back-to-back: in_valid held 1 with ops (0x0001+0x0001) then (0xFFFF+0x0001), out_ready=1 → results 0x0002/cout 0, then 0x0000/cout 1. The second op is accepted exactly one cycle after the first handshake.
